// File: rtl/hue_pkg.sv
// Shared types and helpers for the hue wheel: sector encoding, sector order
// and the per-sector mapping from ramp position to r/g/b duty.
package hue_pkg;

  typedef enum logic [2:0] {
    RED_TO_YELLOW   = 3'd0,
    YELLOW_TO_GREEN = 3'd1,
    GREEN_TO_CYAN   = 3'd2,
    CYAN_TO_BLUE    = 3'd3,
    BLUE_TO_MAGENTA = 3'd4,
    MAGENTA_TO_RED  = 3'd5
  } hue_sector_t;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] g;
    logic [31:0] b;
  } rgb_t;

  function automatic hue_sector_t next_sector(input hue_sector_t s);
    case (s)
      RED_TO_YELLOW:   return YELLOW_TO_GREEN;
      YELLOW_TO_GREEN: return GREEN_TO_CYAN;
      GREEN_TO_CYAN:   return CYAN_TO_BLUE;
      CYAN_TO_BLUE:    return BLUE_TO_MAGENTA;
      BLUE_TO_MAGENTA: return MAGENTA_TO_RED;
      default:         return RED_TO_YELLOW;
    endcase
  endfunction

  // Exactly one channel moves per sector; rise never exceeds full, so fall stays >= 0.
  function automatic rgb_t duty_for(input hue_sector_t s, input logic [31:0] ramp,
                                    input logic [31:0] duty_step, input logic [31:0] full);
    logic [31:0] rise;
    logic [31:0] fall;
    rgb_t        d;
    rise = (ramp + 32'd1) * duty_step;
    fall = full - rise;
    d    = '0;
    case (s)
      RED_TO_YELLOW:   begin d.r = full; d.g = rise; end
      YELLOW_TO_GREEN: begin d.r = fall; d.g = full; end
      GREEN_TO_CYAN:   begin d.g = full; d.b = rise; end
      CYAN_TO_BLUE:    begin d.g = fall; d.b = full; end
      BLUE_TO_MAGENTA: begin d.r = rise; d.b = full; end
      default:         begin d.r = full; d.b = fall; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hue_sequencer_step_timer.sv
// Free-running step timer: pulses tick on the terminal count while enabled,
// freezes its count while disabled.
module step_timer #(
  parameter int TICK_CYCLES = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          terminal;

  assign terminal = (cnt_q == CW'(TICK_CYCLES - 1));
  assign tick     = enable & terminal;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = terminal ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hue_sequencer.sv
// Walks the six-sector hue wheel and presents registered r/g/b duty values
// that only change on a PWM period boundary.
module hue_sequencer
  import hue_pkg::*;
#(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int PWM_INTERVAL = 1200,
  parameter int STEPS        = 200,
  localparam int DW          = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          period_start,
  output logic [DW-1:0] pwm_value_r,
  output logic [DW-1:0] pwm_value_g,
  output logic [DW-1:0] pwm_value_b,
  output logic [2:0]    sector,
  output logic          update
);

  localparam int DUTY_STEP   = PWM_INTERVAL / STEPS;
  localparam int TICK_CYCLES = CLK_FREQ / (6 * STEPS);
  localparam int RW          = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (PWM_INTERVAL % STEPS != 0) begin : g_bad_steps
    $error("hue_sequencer: PWM_INTERVAL must be divisible by STEPS");
  end

  logic tick;

  step_timer #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_step_timer (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  hue_sector_t   sector_q, sector_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic          pending_q, pending_d;
  logic [DW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic          update_q, update_d;
  logic          apply;
  logic          bad_sector;
  rgb_t          duty;

  assign apply      = period_start & (pending_q | tick);
  assign bad_sector = (sector_q > MAGENTA_TO_RED);

  // A tick landing together with period_start is consumed by that step, not latched.
  always_comb begin
    sector_d  = sector_q;
    ramp_d    = ramp_q;
    pending_d = pending_q | tick;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    update_d  = 1'b0;
    duty      = '0;
    if (apply) begin
      pending_d = 1'b0;
      if (ramp_q == RW'(STEPS - 1)) begin
        ramp_d   = '0;
        sector_d = next_sector(sector_q);
      end else begin
        ramp_d = ramp_q + RW'(1);
      end
      duty     = duty_for(sector_d, 32'(ramp_d), 32'(DUTY_STEP), 32'(PWM_INTERVAL));
      r_d      = DW'(duty.r);
      g_d      = DW'(duty.g);
      b_d      = DW'(duty.b);
      update_d = 1'b1;
    end
  end

  // An illegal sector code recovers through the same path as reset.
  always_ff @(posedge clk) begin
    if (reset || bad_sector) begin
      sector_q  <= MAGENTA_TO_RED;
      ramp_q    <= RW'(STEPS - 1);
      pending_q <= 1'b0;
      r_q       <= DW'(PWM_INTERVAL);
      g_q       <= '0;
      b_q       <= '0;
      update_q  <= 1'b0;
    end else begin
      sector_q  <= sector_d;
      ramp_q    <= ramp_d;
      pending_q <= pending_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      update_q  <= update_d;
    end
  end

  assign pwm_value_r = r_q;
  assign pwm_value_g = g_q;
  assign pwm_value_b = b_q;
  assign sector      = sector_q;
  assign update      = update_q;

endmodule

// File: tb/tb_hue_sequencer.sv
// Scoreboard bench for hue_sequencer: expected wheel positions are queued when a
// step is due and checked by an independent monitor on every cycle.
module tb_hue_sequencer;

  localparam int CLK_FREQ     = 1200;
  localparam int PWM_INTERVAL = 12;
  localparam int STEPS        = 4;
  localparam int TICK         = 50;
  localparam int PS_PERIOD    = 12;
  localparam int DW           = 4;
  localparam int WHEEL        = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          period_start;
  logic [DW-1:0] pwm_value_r;
  logic [DW-1:0] pwm_value_g;
  logic [DW-1:0] pwm_value_b;
  logic [2:0]    sector;
  logic          update;

  always #5 clk = ~clk;

  hue_sequencer #(
    .CLK_FREQ    (CLK_FREQ),
    .PWM_INTERVAL(PWM_INTERVAL),
    .STEPS       (STEPS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .period_start(period_start),
    .pwm_value_r (pwm_value_r),
    .pwm_value_g (pwm_value_g),
    .pwm_value_b (pwm_value_b),
    .sector      (sector),
    .update      (update)
  );

  typedef struct {
    int r;
    int g;
    int b;
    int s;
  } exp_t;

  // Hand-computed wheel with DUTY_STEP=3, full scale 12; index 23 is the reset position.
  exp_t wheel [WHEEL] = '{
    '{12, 3, 0, 0}, '{12, 6, 0, 0}, '{12, 9, 0, 0}, '{12, 12, 0, 0},
    '{9, 12, 0, 1}, '{6, 12, 0, 1}, '{3, 12, 0, 1}, '{0, 12, 0, 1},
    '{0, 12, 3, 2}, '{0, 12, 6, 2}, '{0, 12, 9, 2}, '{0, 12, 12, 2},
    '{0, 9, 12, 3}, '{0, 6, 12, 3}, '{0, 3, 12, 3}, '{0, 0, 12, 3},
    '{3, 0, 12, 4}, '{6, 0, 12, 4}, '{9, 0, 12, 4}, '{12, 0, 12, 4},
    '{12, 0, 9, 5}, '{12, 0, 6, 5}, '{12, 0, 3, 5}, '{12, 0, 0, 5}
  };

  exp_t expQ[$];
  exp_t hold;
  int   checks    = 0;
  int   errors    = 0;
  int   mCnt      = 0;
  int   mIdx      = WHEEL - 1;
  bit   mPend     = 1'b0;
  int   mSteps    = 0;
  int   rstCount  = 0;
  int   seenRst   = 0;
  bit   monOn     = 1'b0;
  int   psPhase   = 0;

  task automatic applyStimulus(input bit rst, input bit en, input bit forcePs, input bit autoPs);
    @(negedge clk);
    psPhase      = (psPhase == PS_PERIOD - 1) ? 0 : psPhase + 1;
    reset        = rst;
    enable       = en;
    period_start = forcePs || (autoPs && psPhase == 0);
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    checks++;
    if (pwm_value_r !== DW'(e.r) || pwm_value_g !== DW'(e.g) ||
        pwm_value_b !== DW'(e.b) || sector !== 3'(e.s)) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got rgb=(%0d,%0d,%0d) sector=%0d, want rgb=(%0d,%0d,%0d) sector=%0d",
               name, $time, pwm_value_r, pwm_value_g, pwm_value_b, sector, e.r, e.g, e.b, e.s);
    end
  endtask

  task automatic boundExpired(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference timeline: decides from the driven inputs when a step is due.
  always @(posedge clk) begin
    bit mTick;
    if (reset) begin
      mCnt  = 0;
      mPend = 1'b0;
      mIdx  = WHEEL - 1;
      expQ.delete();
      rstCount++;
    end else begin
      mTick = enable && (mCnt == TICK - 1);
      if (enable) mCnt = (mCnt == TICK - 1) ? 0 : mCnt + 1;
      if (period_start && (mPend || mTick)) begin
        mIdx  = (mIdx + 1) % WHEEL;
        mPend = 1'b0;
        mSteps++;
        expQ.push_back(wheel[mIdx]);
      end else if (mTick) begin
        mPend = 1'b1;
      end
    end
  end

  // Monitor: a queued step must show up with update=1 one edge later; otherwise outputs hold.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rstCount != seenRst) begin
      seenRst = rstCount;
      hold    = wheel[WHEEL - 1];
    end
    if (monOn) begin
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        if (update !== 1'b1) begin
          errors++;
          $display("[TB] FAIL update_pulse at %0t: got update=%b, want 1", $time, update);
        end
        checkOutput("step_value", e);
        hold = e;
      end else begin
        checks++;
        if (update !== 1'b0) begin
          errors++;
          $display("[TB] FAIL spurious_update at %0t: got update=%b, want 0", $time, update);
        end
        checkOutput("hold_value", hold);
      end
    end
  end

  initial begin
    int n;
    reset        = 1'b1;
    enable       = 1'b0;
    period_start = 1'b0;

    // Reset state and first step after release
    applyStimulus(1, 1, 0, 0);
    monOn = 1'b1;
    applyStimulus(1, 1, 0, 0);

    // Full wheel plus one step, normal cadence
    n = 0;
    while (mSteps < WHEEL + 1 && n < (WHEEL + 2) * TICK) begin
      applyStimulus(0, 1, 0, 1);
      n++;
    end
    if (mSteps < WHEEL + 1) boundExpired("free_run");

    // Tick and period_start in the same cycle
    n = 0;
    while (mCnt != TICK - 1 && n < 2 * TICK) begin
      applyStimulus(0, 1, 0, 1);
      n++;
    end
    if (mCnt != TICK - 1) boundExpired("align_tick");
    applyStimulus(0, 1, 1, 0);
    repeat (30) applyStimulus(0, 1, 0, 1);

    // Pending step survives enable=0, then everything freezes
    n = 0;
    while (!mPend && n < 2 * TICK) begin
      applyStimulus(0, 1, 0, 0);
      n++;
    end
    if (!mPend) boundExpired("set_pending");
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    repeat (220) applyStimulus(0, 0, 0, 1);
    repeat (120) applyStimulus(0, 1, 0, 1);

    // Reset mid-sector with a step pending
    n = 0;
    while (mIdx != 9 && n < (WHEEL + 2) * TICK) begin
      applyStimulus(0, 1, 0, 1);
      n++;
    end
    if (mIdx != 9) boundExpired("reach_sector2");
    n = 0;
    while (!mPend && n < 2 * TICK) begin
      applyStimulus(0, 1, 0, 0);
      n++;
    end
    if (!mPend) boundExpired("pending_mid_sector");
    applyStimulus(1, 1, 0, 0);
    repeat (100) applyStimulus(0, 1, 0, 1);

    // Three ticks without period_start coalesce into one step
    repeat (150) applyStimulus(0, 1, 0, 0);
    repeat (120) applyStimulus(0, 1, 0, 1);

    repeat (3) applyStimulus(0, 1, 0, 0);
    monOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hue_sequencer.md
Name: hue_sequencer

Overview:
Upstream colour-generation stage for the RGB fade path. It walks the six-sector hue wheel (red→yellow→green→cyan→blue→magenta→red) once per second. It produces three registered duty values that feed the per-channel pwm instances directly. Duty values change only at PWM period boundaries, so the PWM comparators never see a mid-period change.

Parameters:
CLK_FREQ, 12_000_000, input clock frequency in Hz
PWM_INTERVAL, 1200, PWM period in clocks; also the full-scale duty value
STEPS, 200, duty steps per sector; PWM_INTERVAL must be divisible by STEPS (elaboration check)
Derived: DUTY_STEP = PWM_INTERVAL/STEPS; TICK_CYCLES = CLK_FREQ/(6*STEPS); DW = $clog2(PWM_INTERVAL+1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = step timer runs; 0 = timer frozen
period_start  in  1  one-cycle pulse from pwm counter wrap
pwm_value_r  out  DW  red duty, 0..PWM_INTERVAL
pwm_value_g  out  DW  green duty
pwm_value_b  out  DW  blue duty
sector  out  3  current hue_sector_t encoding
update  out  1  one-cycle pulse coincident with new duty values

Behaviour:
- Reset values (synchronous, sampled on clk edge with reset=1):
  - sector=MAGENTA_TO_RED; ramp=STEPS-1
  - tick_cnt=0; pending=0; update=0
  - outputs r=PWM_INTERVAL, g=0, b=0 (pure red)
- Reset asserted mid-operation returns to this state on the next edge. Any pending step is discarded.
- Step timer:
  - tick_cnt counts 0..TICK_CYCLES-1 while enable=1, then wraps; holds while enable=0.
  - Terminal count asserts tick for one cycle.
- Pending latch:
  - tick sets pending.
  - A second tick while pending=1 coalesces; there is no counter.
- Step application: when period_start=1 AND (pending=1 OR tick=1):
  - Advance one step. Clear pending. Outputs and update take effect on the next edge (1-cycle latency after period_start).
  - A tick in the same cycle as period_start is consumed, not left pending.
  - A pending step is applied even if enable=0.
- Advance rule:
  - If ramp==STEPS-1: ramp←0 and sector←next (MAGENTA_TO_RED wraps to RED_TO_YELLOW).
  - Otherwise ramp←ramp+1.
- Duty values, with rise=(ramp+1)*DUTY_STEP and fall=PWM_INTERVAL-rise:
  - RED_TO_YELLOW: r=FULL, g=rise, b=0
  - YELLOW_TO_GREEN: r=fall, g=FULL, b=0
  - GREEN_TO_CYAN: r=0, g=FULL, b=rise
  - CYAN_TO_BLUE: r=0, g=fall, b=FULL
  - BLUE_TO_MAGENTA: r=rise, g=0, b=FULL
  - MAGENTA_TO_RED: r=FULL, g=0, b=fall
- Continuity: the last step of each sector reaches exactly FULL or 0. No value repeats across a sector boundary. Every step changes exactly one channel by DUTY_STEP.
- Arithmetic: computed at DW bits, unsigned, never negative by construction. Multiply by the constant DUTY_STEP is permitted; no divider in RTL.
- Defaults give 6*200 steps × 10000 clocks = 1 s per wheel. The tick period (10000) exceeds the PWM period (1200), so pending is always consumed before the next tick.
- Encoding: hue_sector_t values 0..5; codes 6/7 are unreachable. If reached, the next edge forces reset state.

Decomposition:
- hue_pkg:
  - hue_sector_t enum (RED_TO_YELLOW=0..MAGENTA_TO_RED=5)
  - next_sector() function
  - duty_for(sector, ramp) function returning the r/g/b triple
- Sub-module step_timer (TICK_CYCLES param; clk, reset, enable → tick). Reused later for fade-rate control.
- hue_sequencer holds the pending latch, sector/ramp state and output registers.

Test Plan:
Bench params: CLK_FREQ=1200, PWM_INTERVAL=12, STEPS=4 → DUTY_STEP=3, TICK_CYCLES=50; period_start every 12 clocks.
1. Reset release → outputs (12,0,0), sector=5, update=0. First tick at cycle 49; next period_start → outputs (12,3,0), sector=0, one update pulse.
2. Free run 24 steps → sequence (12,6,0),(12,9,0),(12,12,0),(9,12,0)…(12,0,3),(12,0,0). Each step differs in one channel by 3; returns to (12,0,0) with sector=5.
3. Force tick and period_start in the same cycle → step applied once on the next edge; pending=0 afterwards; no extra step at the following period_start.
4. enable=0 with pending=1 → step still applied at next period_start; thereafter outputs frozen for ≥200 cycles; tick_cnt value unchanged on re-enable.
5. Assert reset 1 cycle mid-sector (sector=2, ramp=1, pending=1) → next edge outputs (12,0,0), sector=5, pending=0; no update pulse.
6. Hold period_start low for 150 cycles (3 ticks) → no output change; single step on next period_start (coalesced), then normal cadence.
